// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W       = 5;
  localparam int STALL_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    EXC_DRAIN = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use detector: the EX-stage load writes a register the ID instruction reads.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  output logic                 load_use
);

  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, memory-wait holds and exception
// redirect, with a saturating count of frozen-fetch cycles.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_IDX_W-1:0]   id_rs,
  input  logic [REG_IDX_W-1:0]   id_rt,
  input  logic                   id_uses_rt,
  input  logic                   ex_memread,
  input  logic [REG_IDX_W-1:0]   ex_rt,
  input  logic                   id_branch_taken,
  input  logic                   id_jump,
  input  logic                   exc_req,
  input  logic                   dmem_wait,
  input  logic                   imem_wait,
  output logic                   pc_ifwrite,
  output logic                   if_flush,
  output logic                   idex_bubble,
  output logic                   pipe_hold,
  output logic                   exmem_flush,
  output logic                   exc_pc_sel,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  hz_state_t              state, nxt_state;
  logic                   exc_pending, nxt_exc_pending;
  logic                   load_use;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  load_use_detect u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  always_comb begin
    pc_ifwrite      = 1'b1;
    if_flush        = 1'b0;
    idex_bubble     = 1'b0;
    pipe_hold       = 1'b0;
    exmem_flush     = 1'b0;
    exc_pc_sel      = 1'b0;
    nxt_state       = state;
    nxt_exc_pending = exc_pending;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (exc_req) begin
            if_flush    = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            exc_pc_sel  = 1'b1;
            nxt_state   = EXC_DRAIN;
          end else if (dmem_wait) begin
            pc_ifwrite = 1'b0;
            pipe_hold  = 1'b1;
            nxt_state  = MEM_WAIT;
          end else if (load_use) begin
            // One-cycle stall: the bubble drops ex_memread next cycle.
            pc_ifwrite  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_branch_taken || id_jump) begin
            if_flush = 1'b1;
          end else if (imem_wait) begin
            pc_ifwrite  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_wait) begin
            // Exceptions arriving mid-wait are remembered until memory is ready.
            pc_ifwrite = 1'b0;
            pipe_hold  = 1'b1;
            if (exc_req) nxt_exc_pending = 1'b1;
          end else if (exc_pending || exc_req) begin
            if_flush        = 1'b1;
            idex_bubble     = 1'b1;
            exmem_flush     = 1'b1;
            exc_pc_sel      = 1'b1;
            nxt_exc_pending = 1'b0;
            nxt_state       = EXC_DRAIN;
          end else begin
            nxt_state = RUN;
          end
        end
        EXC_DRAIN: begin
          if_flush    = 1'b1;
          idex_bubble = 1'b1;
          nxt_state   = RUN;
        end
        default: nxt_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      exc_pending  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state       <= nxt_state;
      exc_pending <= nxt_exc_pending;
      if (!pc_ifwrite) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
